crc8_frame_checker: RTL
=======================

Name: crc8_frame_checker

Overview:
- Receive-side counterpart of the team's byte-serial CRC-8 generator (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR).
- Accepts a byte stream whose final byte of each frame is the transmitted CRC.
- Forwards the payload with the CRC byte stripped, and reports one pass/fail status per frame.
- Sits between the link deserializer and the packet consumer.

Parameters:
CNT_W, 16, width of the saturating CRC-error counter
MIN_PAYLOAD, 1, minimum payload bytes (excluding CRC); shorter frames are flagged runt

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
s_data  in  8  input byte
s_valid  in  1  input byte valid
s_last  in  1  marks the CRC byte (final byte of frame)
s_ready  out  1  input accept
m_data  out  8  payload byte out
m_valid  out  1  output valid
m_last  out  1  last payload byte of frame
m_ready  in  1  downstream accept
status_valid  out  1  one-cycle pulse per completed frame
status_ok  out  1  CRC matched and frame not runt
status_runt  out  1  payload length < MIN_PAYLOAD
status_crc_rx  out  8  received CRC byte
status_crc_calc  out  8  computed CRC over the payload
err_count  out  CNT_W  saturating count of frames with status_ok=0

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset values: all outputs 0; internal crc_reg=0x00, hold register empty, payload length counter=0, FSM=IDLE.
- Handshake:
  - s_ready = !m_valid || m_ready, combinational.
  - A beat is accepted when s_valid && s_ready.
  - m_data/m_last/m_valid are registered and stay stable while m_valid && !m_ready.
- FSM states:
  - IDLE: hold register empty.
  - HOLD: one payload byte held, its position unknown until the next beat arrives.
- IDLE, accept !s_last: hold<=s_data; crc_reg<=crc8_next(crc_reg,s_data); len<=1; ->HOLD. No output produced.
- IDLE, accept s_last: zero-payload frame. No output beat. Status pulse with runt=1, ok=0, crc_calc=0x00, crc_rx=s_data. Stay IDLE.
- HOLD, accept !s_last: m_data<=hold, m_last<=0, m_valid<=1; hold<=s_data; crc_reg updated; len++ (saturating at MIN_PAYLOAD). Stay HOLD.
- HOLD, accept s_last:
  - m_data<=hold, m_last<=1, m_valid<=1.
  - status_crc_calc<=crc_reg, status_crc_rx<=s_data.
  - status_runt<=(len<MIN_PAYLOAD).
  - status_ok<=(crc_reg==s_data)&&!runt.
  - crc_reg<=0x00; len<=0; ->IDLE.
- Status timing:
  - status_valid pulses exactly one cycle, in the cycle after the s_last beat is accepted.
  - The status_* values hold until the next pulse.
- err_count: increments in the cycle status_valid goes high with status_ok=0; saturates at all-ones.
- Output clears: m_valid clears on m_ready when no new beat loads in the same cycle. A simultaneous m_ready and new load overwrites the register (full throughput, 1 byte/cycle).
- Latency: a payload byte appears on m_data one cycle after the following input byte is accepted.
- Reset mid-frame: partial frame discarded; no status pulse; err_count cleared.
- s_data/s_last are ignored when !s_valid.
- X-free: the CRC update uses only accepted bytes.

Decomposition:
- Shared package crc8_pkg holds:
  - CRC8_POLY=8'h07 and CRC8_INIT=8'h00.
  - Function crc8_next(crc,data), the MSB-first byte update.
  - The state enum for IDLE and HOLD.
- The existing generator is migrated to the same function.
- No sub-module; a single module with the FSM, hold register, output register and counters.

Test Plan:
- Frame "123456789" (0x31..0x39) + CRC 0xF4, m_ready=1 -> 9 bytes out, m_last on 0x39, status_ok=1, crc_calc=0xF4, err_count=0.
- Frame 0x01 + CRC 0x07, then 0x00 + CRC 0x00 back-to-back, no idle cycles -> two status pulses both ok, outputs 0x01 then 0x00 each with m_last=1.
- "123456789" + CRC 0xF5 -> status_ok=0, crc_rx=0xF5, crc_calc=0xF4, err_count=1; payload still forwarded intact.
- Lone s_last beat 0x00 -> no m_valid, status_runt=1, ok=0, err_count+1. Also MIN_PAYLOAD=4 with a 3-byte payload -> runt=1.
- Random m_ready backpressure (~50%) over 20 random valid frames -> no loss or duplication, s_ready low exactly when m_valid && !m_ready, all ok.
- Assert reset_n mid-frame after 4 bytes, then send a clean frame "123456789"+0xF4 -> no status for the partial frame, clean frame ok, err_count=0.

Source files
------------

// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions (poly 0x07, init 0x00, MSB-first, no reflection,
// no final XOR) used by both the transmit-side generator and the receive-side
// frame checker, so the two ends can never disagree on the polynomial.
package crc8_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;

    // Frame checker FSM: IDLE has nothing held; HOLD has one payload byte
    // waiting because we cannot tell whether it is the last payload byte
    // until the following beat (payload or CRC) shows up.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } crc8_state_t;

    // One-byte MSB-first CRC-8 update: fold the byte into the register,
    // then run eight shift/conditional-XOR steps.
    function automatic logic [7:0] crc8_next(input logic [7:0] crc,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ CRC8_POLY;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_frame_checker.sv
// Receive-side CRC-8 frame checker. Accepts a byte stream whose final beat
// of every frame is the transmitted CRC, forwards the payload with the CRC
// byte stripped, and emits a single-cycle status pulse per completed frame.
// A one-byte hold register delays each payload byte until the next beat
// reveals whether it was the last payload byte, which keeps the datapath at
// one byte per cycle without any lookahead on the input side.
module crc8_frame_checker
    import crc8_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MIN_PAYLOAD = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             status_valid,
    output logic             status_ok,
    output logic             status_runt,
    output logic [7:0]       status_crc_rx,
    output logic [7:0]       status_crc_calc,
    output logic [CNT_W-1:0] err_count
);

    // The length counter only has to reach MIN_PAYLOAD (it saturates there),
    // so it is sized for that value rather than for the longest frame.
    localparam int LEN_W = (MIN_PAYLOAD < 1) ? 1 : $clog2(MIN_PAYLOAD + 1);
    localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_PAYLOAD);
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    crc8_state_t      state_r;
    logic [7:0]       hold_r;
    logic [7:0]       crc_r;
    logic [LEN_W-1:0] len_r;

    logic             accept_s;
    logic             runt_s;
    logic             crc_match_s;
    logic [7:0]       crc_upd_s;
    logic [LEN_W-1:0] len_inc_s;
    logic [CNT_W-1:0] err_inc_s;

    // The output register can take a new byte whenever it is empty or is
    // being drained in this same cycle.
    assign s_ready  = !m_valid || m_ready;
    assign accept_s = s_valid && s_ready;

    // Next-value helpers: CRC update over the incoming byte, saturating
    // payload length, saturating error count and frame verdict terms.
    always_comb begin
        crc_upd_s   = crc8_next(crc_r, s_data);
        runt_s      = (len_r < LEN_MIN);
        crc_match_s = (crc_r == s_data);
        if (len_r < LEN_MIN) begin
            len_inc_s = len_r + LEN_ONE;
        end else begin
            len_inc_s = len_r;
        end
        if (err_count == CNT_MAX) begin
            err_inc_s = err_count;
        end else begin
            err_inc_s = err_count + CNT_ONE;
        end
    end

    // Frame FSM, hold register, output register, status and error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r         <= ST_IDLE;
            hold_r          <= 8'h00;
            crc_r           <= CRC8_INIT;
            len_r           <= LEN_ZERO;
            m_data          <= 8'h00;
            m_valid         <= 1'b0;
            m_last          <= 1'b0;
            status_valid    <= 1'b0;
            status_ok       <= 1'b0;
            status_runt     <= 1'b0;
            status_crc_rx   <= 8'h00;
            status_crc_calc <= 8'h00;
            err_count       <= {CNT_W{1'b0}};
        end else begin
            status_valid <= 1'b0;
            // Drained by downstream; a load below in the same cycle wins.
            if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (accept_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (!s_last) begin
                            hold_r  <= s_data;
                            crc_r   <= crc_upd_s;
                            len_r   <= LEN_ONE;
                            state_r <= ST_HOLD;
                        end else begin
                            // CRC byte with no payload in front of it.
                            status_valid    <= 1'b1;
                            status_ok       <= 1'b0;
                            status_runt     <= 1'b1;
                            status_crc_calc <= CRC8_INIT;
                            status_crc_rx   <= s_data;
                            err_count       <= err_inc_s;
                        end
                    end
                    ST_HOLD: begin
                        m_data  <= hold_r;
                        m_valid <= 1'b1;
                        m_last  <= s_last;
                        if (!s_last) begin
                            hold_r <= s_data;
                            crc_r  <= crc_upd_s;
                            len_r  <= len_inc_s;
                        end else begin
                            // s_data is the received CRC, not payload.
                            status_valid    <= 1'b1;
                            status_ok       <= crc_match_s && !runt_s;
                            status_runt     <= runt_s;
                            status_crc_calc <= crc_r;
                            status_crc_rx   <= s_data;
                            if (!(crc_match_s && !runt_s)) begin
                                err_count <= err_inc_s;
                            end
                            crc_r   <= CRC8_INIT;
                            len_r   <= LEN_ZERO;
                            state_r <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        crc_r   <= CRC8_INIT;
                        len_r   <= LEN_ZERO;
                    end
                endcase
            end
        end
    end

endmodule
